// File: rtl/rv32_muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
`timescale 1ns/1ps
package rv32_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_rs1(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rs2(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic wants_high(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/rv32_muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring trial-subtract divide.
// The quotient bit is returned separately; the caller merges it into bit 0 of the accumulator.
`timescale 1ns/1ps
module rv32_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0]   mulSum;
  logic [XLEN:0]   remShift;
  logic [XLEN-1:0] remDiff;

  // Multiply keeps the multiplier in the low half and shifts the product in from the top;
  // divide keeps the remainder in the high half and shifts dividend bits out of the low half.
  always_comb begin
    mulSum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    remShift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    remDiff  = remShift[XLEN-1:0] - operand_i;
    qbit_o   = 1'b0;
    acc_o    = {mulSum, acc_i[XLEN-1:1]};
    if (div_i) begin
      qbit_o = (remShift >= {1'b0, operand_i});
      acc_o  = {(qbit_o ? remDiff : remShift[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready request side and one-cycle result pulse.
// Define RV32_MULDIV_FAST_MUL_EN to compute multiplies in a single cycle (division stays iterative).
`timescale 1ns/1ps
module rv32_muldiv
  import rv32_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            flush_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN);

  state_e            state_q, state_d;
  op_e               op_q, opIn;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, stepAcc, prod;
  logic [XLEN-1:0]   opnd_q, rs1_q, result_q, fixResult, mag1, mag2, quo, rem;
  logic              sign1_q, sign2_q, divZero_q, sign1, sign2, stepQbit, accept, fastGo;

  assign opIn   = op_e'(op_in);
  assign accept = valid_in && ready_out && !flush_in;
  assign sign1  = is_signed_rs1(opIn) && rs1_value_in[XLEN-1];
  assign sign2  = is_signed_rs2(opIn) && rs2_value_in[XLEN-1];
  assign mag1   = sign1 ? -rs1_value_in : rs1_value_in;
  assign mag2   = sign2 ? -rs2_value_in : rs2_value_in;

`ifdef RV32_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fastA, fastB, fastProd;
  logic        [XLEN-1:0]   fastResult;

  // Sign-extending to 2*XLEN is the (XLEN+1)x(XLEN+1) signed product truncated to what we need.
  assign fastGo     = !is_div(opIn);
  assign fastA      = {{XLEN{sign1}}, rs1_value_in};
  assign fastB      = {{XLEN{sign2}}, rs2_value_in};
  assign fastProd   = fastA * fastB;
  assign fastResult = wants_high(opIn) ? fastProd[2*XLEN-1:XLEN] : fastProd[XLEN-1:0];
`else
  assign fastGo = 1'b0;
`endif

  rv32_muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i     (is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (stepAcc),
    .qbit_o    (stepQbit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = fastGo ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = FIXUP;
        FIXUP:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_out = (state_q == IDLE);
    valid_out = (state_q == DONE) && !flush_in;
  end

  // Sign correction; divide-by-zero overrides both results, overflow falls out of the magnitudes.
  always_comb begin
    prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    quo  = (sign1_q ^ sign2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (divZero_q) begin
      quo = '1;
      rem = rs1_q;
    end
    if (is_div(op_q)) fixResult = is_rem(op_q) ? rem : quo;
    else              fixResult = wants_high(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rs1_q     <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      divZero_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= opIn;
        rs1_q     <= rs1_value_in;
        sign1_q   <= sign1;
        sign2_q   <= sign2;
        divZero_q <= (rs2_value_in == '0);
        cnt_q     <= CW'(XLEN - 1);
        if (is_div(opIn)) begin
          acc_q  <= {{XLEN{1'b0}}, mag1};
          opnd_q <= mag2;
        end else begin
          acc_q  <= {{XLEN{1'b0}}, mag2};
          opnd_q <= mag1;
        end
      end else if (state_q == CALC && !flush_in) begin
        acc_q <= stepAcc | {{(2*XLEN-1){1'b0}}, stepQbit};
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
      if (state_q == FIXUP && !flush_in) result_q <= fixResult;
`ifdef RV32_MULDIV_FAST_MUL_EN
      if (accept && fastGo) result_q <= fastResult;
`endif
    end
  end

  assign result_out = result_q;

endmodule
